// File: rtl/chess_timer_pkg.sv
// ---------------------------------------------------------------------------
// chess_timer_pkg
// Constants shared by the chess-timer front end.
//   BTN_ENABLE/BTN_RESET/BTN_SET/BTN_ADD : bit positions of the buttons in
//                                          the btn_* vectors
//   N_BTN_DEFAULT, N_SW                  : channel counts
//   *_DEFAULT                            : default debounce/repeat timing,
//                                          in clk cycles
//   cnt_width()                          : width of a counter that must
//                                          hold the value n
// ---------------------------------------------------------------------------
package chess_timer_pkg;

    localparam int BTN_ENABLE = 0;
    localparam int BTN_RESET  = 1;
    localparam int BTN_SET    = 2;
    localparam int BTN_ADD    = 3;

    localparam int N_BTN_DEFAULT = 4;
    localparam int N_SW          = 2;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int REPEAT_DELAY_DEFAULT    = 50000000;
    localparam int REPEAT_PERIOD_DEFAULT   = 10000000;

    // Only the add button auto-repeats by default.
    localparam logic [N_BTN_DEFAULT-1:0] REPEAT_MASK_DEFAULT =
        N_BTN_DEFAULT'(1) << BTN_ADD;

    // Width of a counter able to hold the value n (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
// One conditioned input channel: two-flop synchronizer, stability counter,
// debounced level, rising-edge press pulse and, when the build defines
// BTN_AUTOREPEAT_EN, an optional auto-repeat timer.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   raw    in   asynchronous raw level
//   level  out  debounced level
//   press  out  one-cycle pulse per accepted press (and per repeat);
//               tied low when PRESS_EN is 0
//
// Timing: a stable raw change shows up on level 2+DEBOUNCE_CYCLES edges
// after the first edge that samples it (2 synchronizer edges, then the
// counter needs DEBOUNCE_CYCLES edges of disagreement). press rises on the
// same edge that level goes 0->1.
//
// Macro BTN_AUTOREPEAT_EN: adds REPEAT_EN/REPEAT_DELAY/REPEAT_PERIOD
// parameters and the repeat timer. Without it no repeat logic exists.
// ---------------------------------------------------------------------------
module debounce_ch
    import chess_timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit PRESS_EN        = 1'b1
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    // The edge that would bring the counter to DEBOUNCE_CYCLES toggles the
    // level instead, so the counter itself never exceeds DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;

    logic          differ;
    logic          accept;
    logic          rise;
    logic          fall;
    logic          rep_fire;

    assign differ = (sync2 != level_q);
    assign accept = differ && (cnt == CNT_LAST);
    assign rise   = accept && !level_q;
    assign fall   = accept && level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            // Any agreement (glitch ended) or an accepted change restarts
            // the stability count from zero.
            if (!differ || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                level_q <= ~level_q;
            end
            press_q <= PRESS_EN && (rise || rep_fire);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_EN && PRESS_EN) begin : g_repeat
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                             : REPEAT_PERIOD;
        localparam int RW   = cnt_width(RMAX);

        logic [RW-1:0] rcnt;
        logic          periodic;  // 0: waiting out the initial delay
        logic [RW-1:0] rlast;
        logic          hold;

        // hold: level is high now and stays high across this edge. The
        // timer starts counting on the edge after the initial press pulse.
        assign hold     = level_q && !fall;
        assign rlast    = periodic ? RW'(REPEAT_PERIOD - 1)
                                   : RW'(REPEAT_DELAY - 1);
        assign rep_fire = hold && (rcnt == rlast);

        always_ff @(posedge clk) begin
            if (reset || !hold) begin
                rcnt     <= '0;
                periodic <= 1'b0;
            end else if (rep_fire) begin
                rcnt     <= '0;
                periodic <= 1'b1;
            end else begin
                rcnt     <= rcnt + 1'b1;
            end
        end
    end else begin : g_no_repeat
        assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Synchronizes and debounces the chess-timer push buttons and player
// switches; produces debounced levels and one-cycle press pulses.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   btn_raw    in   [N_BTN] raw buttons (enable, reset, set, add)
//   sw_raw     in   [2]     raw player switches (bit0 p1, bit1 p2)
//   btn_level  out  [N_BTN] debounced button levels
//   btn_press  out  [N_BTN] one-cycle press pulses (and repeats)
//   sw_level   out  [2]     debounced switch levels (no pulses)
//
// Macro BTN_AUTOREPEAT_EN: buttons selected by REPEAT_MASK emit repeat
// pulses while held. Undefined: one pulse per press, REPEAT_* unused.
// ---------------------------------------------------------------------------
module btn_conditioner
    import chess_timer_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [1:0]       sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [1:0]       sw_level
);

    logic [1:0] sw_press_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PRESS_EN        (1'b1)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_EN       (REPEAT_MASK[i]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i])
        );
    end

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PRESS_EN        (1'b0)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[j]),
            .level (sw_level[j]),
            .press (sw_press_unused[j])
        );
    end

`ifndef BTN_AUTOREPEAT_EN
    // Repeat configuration has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (^REPEAT_MASK) ^ (REPEAT_DELAY > 0)
                               ^ (REPEAT_PERIOD > 0);
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Inputs change just after a falling
// edge; "edge k" is the k-th rising edge after that change, and outputs
// are sampled at the falling edge that follows edge k.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N_BTN = 4;
    localparam int DB    = 4;
    localparam int LAT   = 2 + DB;   // edges from raw change to level

    logic             clk;
    logic             reset;
    logic [N_BTN-1:0] btn_raw;
    logic [1:0]       sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [1:0]       sw_level;

    int n_checks = 0;
    int n_fail   = 0;

    btn_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_MASK     (4'b1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .sw_level  (sw_level)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: advance one rising edge, return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        idle(3);
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_btn_level: got %b expected 0000", btn_level);
        end
        n_checks++;
        if (btn_press !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_btn_press: got %b expected 0000", btn_press);
        end
        n_checks++;
        if (sw_level !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_sw_level: got %b expected 00", sw_level);
        end
        reset = 1'b0;
        idle(4);
        n_checks++;
        if ({btn_level, btn_press, sw_level} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected all 0",
                     {btn_level, btn_press, sw_level});
        end
    endtask

    // add button: press, hold, release
    task automatic test_single_press();
        logic [N_BTN-1:0] exp_level;
        logic [N_BTN-1:0] exp_press;
        btn_raw = 4'b1000;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b1000 : 4'b0000;
            exp_press = (k == LAT) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (btn_level !== exp_level) begin
                n_fail++;
                $display("FAIL press_level edge %0d: got %b expected %b",
                         k, btn_level, exp_level);
            end
            n_checks++;
            if (btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL press_pulse edge %0d: got %b expected %b",
                         k, btn_press, exp_press);
            end
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b0000 : 4'b1000;
            n_checks++;
            if (btn_level !== exp_level || btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL release edge %0d: level %b press %b expected level %b press 0000",
                         k, btn_level, btn_press, exp_level);
            end
        end
    endtask

    // set button high for 3 cycles only: too short to be accepted
    task automatic test_glitch();
        btn_raw = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) btn_raw = 4'b0000;
            step();
            n_checks++;
            if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL glitch edge %0d: level %b press %b expected 0000/0000",
                         k, btn_level, btn_press);
            end
        end
    endtask

    // enable + set pressed together, then released together
    task automatic test_simultaneous();
        logic [N_BTN-1:0] exp_level;
        logic [N_BTN-1:0] exp_press;
        btn_raw = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b0101 : 4'b0000;
            exp_press = (k == LAT) ? 4'b0101 : 4'b0000;
            n_checks++;
            if (btn_level !== exp_level || btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL simul_press edge %0d: level %b press %b expected %b/%b",
                         k, btn_level, btn_press, exp_level, exp_press);
            end
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b0000 : 4'b0101;
            n_checks++;
            if (btn_level !== exp_level || btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL simul_release edge %0d: level %b press %b expected %b/0000",
                         k, btn_level, btn_press, exp_level);
            end
        end
    endtask

    // enable held across reset: counts as a fresh press after release
    task automatic test_held_through_reset();
        logic [N_BTN-1:0] exp_level;
        logic [N_BTN-1:0] exp_press;
        reset   = 1'b1;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL held_in_reset edge %0d: level %b press %b expected 0000/0000",
                         k, btn_level, btn_press);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b0001 : 4'b0000;
            exp_press = (k == LAT) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (btn_level !== exp_level || btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL held_release edge %0d: level %b press %b expected %b/%b",
                         k, btn_level, btn_press, exp_level, exp_press);
            end
        end
        btn_raw = 4'b0000;
        idle(LAT + 2);
    endtask

    // reset at edge 4 of a debounce aborts it; counting restarts from zero
    task automatic test_reset_mid_debounce();
        logic [N_BTN-1:0] exp_level;
        logic [N_BTN-1:0] exp_press;
        btn_raw = 4'b1000;
        idle(3);
        reset = 1'b1;
        step();
        n_checks++;
        if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset: level %b press %b expected 0000/0000",
                     btn_level, btn_press);
        end
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_level = (k >= LAT) ? 4'b1000 : 4'b0000;
            exp_press = (k == LAT) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (btn_level !== exp_level || btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL mid_reset_restart edge %0d: level %b press %b expected %b/%b",
                         k, btn_level, btn_press, exp_level, exp_press);
            end
        end
        btn_raw = 4'b0000;
        idle(LAT + 2);
    endtask

    // switches debounce but never pulse
    task automatic test_switches();
        logic [1:0] exp_sw;
        sw_raw = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_sw = (k >= LAT) ? 2'b11 : 2'b00;
            n_checks++;
            if (sw_level !== exp_sw || btn_press !== 4'b0000 || btn_level !== 4'b0000) begin
                n_fail++;
                $display("FAIL sw_on edge %0d: sw %b press %b level %b expected sw %b, buttons 0",
                         k, sw_level, btn_press, btn_level, exp_sw);
            end
        end
        sw_raw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_sw = (k >= LAT) ? 2'b01 : 2'b11;
            n_checks++;
            if (sw_level !== exp_sw || btn_press !== 4'b0000) begin
                n_fail++;
                $display("FAIL sw_p2_off edge %0d: sw %b press %b expected sw %b press 0000",
                         k, sw_level, btn_press, exp_sw);
            end
        end
        sw_raw = 2'b00;
        idle(LAT + 2);
    endtask

    // add + enable held 25 edges; expected pulse edges come from exp_q
    task automatic test_hold();
        logic [7:0]       exp_q[$];
        logic [N_BTN-1:0] exp_press;
`ifdef BTN_AUTOREPEAT_EN
        exp_q = '{8'd6, 8'd16, 8'd19, 8'd22, 8'd25};
`else
        exp_q = '{8'd6};
`endif
        btn_raw = 4'b1001;
        for (int k = 1; k <= 25; k++) begin
            step();
            exp_press = (k == LAT) ? 4'b0001 : 4'b0000;
            if (exp_q.size() > 0 && int'(exp_q[0]) == k) begin
                exp_press[3] = 1'b1;
                void'(exp_q.pop_front());
            end
            n_checks++;
            if (btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL hold_pulse edge %0d: got %b expected %b",
                         k, btn_press, exp_press);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL hold_pulse_count: %0d expected pulses not seen, expected 0",
                     exp_q.size());
        end
        btn_raw = 4'b0000;
        idle(LAT + 1);
        n_checks++;
        if (btn_level !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_release_level: got %b expected 0000", btn_level);
        end
        idle(4);
        n_checks++;
        if (btn_press !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_after_release: got %b expected 0000", btn_press);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_held_through_reset();
        test_reset_mid_debounce();
        test_switches();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, 4, number of push-button channels (enable, reset, set, add, in that bit order).
REQ-002 Parameter DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required before a level change is accepted; legal range >= 1.
REQ-003 Parameter REPEAT_DELAY, 50000000, held-cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-005 Parameter REPEAT_MASK, 4'b1000, channels eligible for auto-repeat (default: add only).
REQ-006 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port btn_raw  input  N_BTN  asynchronous raw push-button levels, active-high.
REQ-009 Port sw_raw  input  2  asynchronous raw player switches (bit0 player1, bit1 player2).
REQ-010 Port btn_level  output  N_BTN  debounced button levels.
REQ-011 Port btn_press  output  N_BTN  one-cycle pulse per accepted press (and per repeat).
REQ-012 Port sw_level  output  2  debounced switch levels.

Function
REQ-013 Each of the N_BTN+2 channels SHALL pass its raw input through a two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a stability counter of width $clog2(DEBOUNCE_CYCLES+1), cleared whenever the synchronized sample equals the current debounced level.
REQ-015 While the synchronized sample differs from the debounced level, the counter SHALL increment each cycle; when it reaches DEBOUNCE_CYCLES the debounced level SHALL toggle and the counter SHALL clear in the same edge.
REQ-016 A raw change held stable SHALL appear on the level output exactly 2+DEBOUNCE_CYCLES clock edges after the first edge that samples it.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL reset the counter and SHALL NOT change the level or produce a pulse.
REQ-018 btn_press[i] SHALL be high for exactly the one cycle following the edge at which btn_level[i] goes 0->1; a 1->0 transition SHALL produce no pulse.
REQ-019 Channels SHALL operate fully independently; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 Switch channels SHALL produce no press pulses.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES (no wrap-around).

Reset
REQ-022 While reset is high at an edge, all synchronizer flops, counters, repeat timers, btn_level, btn_press and sw_level SHALL become 0.
REQ-023 A button already held at reset release SHALL be treated as a new press: its level rises and one pulse fires after the REQ-016 latency.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort that operation with no pulse emitted.

Configuration
REQ-025 With macro BTN_AUTOREPEAT_EN defined, each channel in REPEAT_MASK whose level stays high SHALL emit an extra btn_press pulse REPEAT_DELAY cycles after the initial pulse and then every REPEAT_PERIOD cycles; the level falling SHALL stop repetition and clear the timer immediately.
REQ-026 With BTN_AUTOREPEAT_EN undefined, repeat timers SHALL NOT be synthesized, exactly one pulse per press SHALL be produced, and REPEAT_* parameters SHALL be ignored.

Structure
REQ-027 Shared package chess_timer_pkg SHALL hold button index constants (BTN_ENABLE=0, BTN_RESET=1, BTN_SET=2, BTN_ADD=3) and default DEBOUNCE_CYCLES/REPEAT_* values.
REQ-028 A single sub-module debounce_ch (synchronizer, counter, level, edge pulse, optional repeat timer) SHALL be instantiated once per channel via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 btn_raw[3] 0->1 held -> btn_level[3]=1 at edge 6, btn_press[3]=1 for exactly cycle 6 only.
REQ-030 btn_raw[2] pulses high for 3 cycles then low -> btn_level[2] and btn_press[2] stay 0 throughout.
REQ-031 btn_raw=4'b0101 simultaneously -> btn_press=4'b0101 in one common cycle; release -> no pulses.
REQ-032 btn_raw[0] high through reset, release reset -> level 0 during reset, single pulse 6 edges after release.
REQ-033 reset asserted at edge 4 of a debounce -> no pulse, counters 0, level 0.
REQ-034 BTN_AUTOREPEAT_EN defined, btn_raw[3] held 25 cycles -> pulses at cycles 6, 16, 19, 22, 25 (clipped by release); btn_raw[0] held -> single pulse only.
